// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Also counts output bubble cycles with a saturating counter.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic xfer_in;
  logic xfer_out;

  if (SKID != 0) begin : g_skid
    // State is the pair {skid valid, main valid}; FULL means both entries live.
    typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;

    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = rdy_q;
    assign xfer_in   = in_valid & rdy_q;
    assign xfer_out  = out_valid & out_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = S_EMPTY;
      end else begin
        unique case (state_q)
          S_EMPTY: begin
            if (xfer_in) begin
              main_d  = in_data;
              state_d = S_ONE;
            end
          end
          S_ONE: begin
            if (xfer_in && xfer_out) begin
              main_d = in_data;
            end else if (xfer_in) begin
              skid_d  = in_data;
              state_d = S_FULL;
            end else if (xfer_out) begin
              state_d = S_EMPTY;
            end
          end
          S_FULL: begin
            if (xfer_out) begin
              main_d  = skid_q;
              state_d = S_ONE;
            end
          end
          default: state_d = S_EMPTY;
        endcase
      end
    end

    // Ready is registered from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != S_FULL);
      end
    end
  end else begin : g_direct
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    assign out_valid = vld_q;
    assign out_data  = dat_q;
    assign in_ready  = ~vld_q | out_ready;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = vld_q & out_ready;

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (xfer_in) begin
        vld_d = 1'b1;
        dat_d = in_data;
      end else if (xfer_out) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!out_valid) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 (CNT_W=16) and SKID=1 (CNT_W=4) instances share one stimulus.
// Directed table rows, hand sequences, then random traffic against a capacity-limited queue model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, flush, cnt_clr;
  logic [31:0] in_data;
  logic [1:0]  ir_w, ov_w;
  logic [31:0] od_w [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[0]), .in_data(in_data),
    .out_valid(ov_w[0]), .out_ready(out_ready), .out_data(od_w[0]), .flush(flush),
    .cnt_clr(cnt_clr), .bubble_cnt(cnt0));

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[1]), .in_data(in_data),
    .out_valid(ov_w[1]), .out_ready(out_ready), .out_data(od_w[1]), .flush(flush),
    .cnt_clr(cnt_clr), .bubble_cnt(cnt1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int unsigned mcnt [2];
  int unsigned mmax [2] = '{65535, 15};
  bit          model_on = 1'b0;
  logic [1:0]  pstall = 2'b00;
  logic [31:0] pod [2];

  function automatic int msize(input int d);
    return (d != 0) ? mq1.size() : mq0.size();
  endfunction

  function automatic logic [31:0] mhead(input int d);
    if (d != 0) return (mq1.size() > 0) ? mq1[0] : 32'h0;
    return (mq0.size() > 0) ? mq0[0] : 32'h0;
  endfunction

  function automatic logic m_ir(input int d);
    if (d != 0) return (mq1.size() < 2);
    return (mq0.size() == 0) || out_ready;
  endfunction

  function automatic logic [15:0] dut_cnt(input int d);
    return (d != 0) ? {12'h0, cnt1} : cnt0;
  endfunction

  task automatic tick_check();
    @(negedge clk);
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m_ov%0d", d), {31'h0, ov_w[d]}, {31'h0, msize(d) > 0});
        if (msize(d) > 0) chk($sformatf("m_od%0d", d), od_w[d], mhead(d));
        chk($sformatf("m_ir%0d", d), {31'h0, ir_w[d]}, {31'h0, m_ir(d)});
        chk($sformatf("m_cnt%0d", d), {16'h0, dut_cnt(d)}, mcnt[d]);
        if (pstall[d]) chk($sformatf("stall_od%0d", d), od_w[d], pod[d]);
      end
    end
  endtask

  task automatic tick_advance();
    for (int d = 0; d < 2; d++) begin
      pstall[d] = (ov_w[d] === 1'b1) && !out_ready && !flush && rst_n;
      pod[d]    = od_w[d];
    end
    for (int d = 0; d < 2; d++) begin
      logic        ir, empty;
      logic [31:0] q[$];
      if (d != 0) q = mq1; else q = mq0;
      ir    = m_ir(d);
      empty = (q.size() == 0);
      if (!rst_n) begin
        q.delete();
        mcnt[d] = 0;
      end else begin
        if (cnt_clr) mcnt[d] = 0;
        else if (empty && mcnt[d] < mmax[d]) mcnt[d] = mcnt[d] + 1;
        if (flush) begin
          q.delete();
        end else begin
          if (!empty && out_ready) void'(q.pop_front());
          if (in_valid && ir) q.push_back(in_data);
        end
      end
      if (d != 0) mq1 = q; else mq0 = q;
    end
    if (!rst_n) model_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n, iv;
    logic [31:0] id;
    logic        ordy, fl, clr;
    logic [1:0]  msk;
    logic        c_ir, c_ov, c_od, c_cnt;
    logic [1:0]  e_ir, e_ov;
    logic [31:0] e_od0, e_od1;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t v(input logic r, iv, input logic [31:0] id, input logic ordy, fl, clr,
                             input logic [1:0] msk, input logic cir, cov, cod, ccnt,
                             input logic [1:0] eir, eov, input logic [31:0] eod0, eod1,
                             input logic [15:0] ecnt);
    vec_t t;
    t.rst_n = r;  t.iv = iv;  t.id = id;  t.ordy = ordy;  t.fl = fl;  t.clr = clr;
    t.msk = msk;  t.c_ir = cir;  t.c_ov = cov;  t.c_od = cod;  t.c_cnt = ccnt;
    t.e_ir = eir;  t.e_ov = eov;  t.e_od0 = eod0;  t.e_od1 = eod1;  t.e_cnt = ecnt;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic sv;
    rst_n = 1'b0;  in_valid = 1'b0;  in_data = '0;  out_ready = 1'b1;  flush = 1'b0;  cnt_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset then stream 0x10..0x13 (both modes), counter clear.
    tbl.push_back(v(0,0,0,1,0,0, 2'b00, 0,0,0,0, 2'b00,2'b00, 0,0, 0));
    tbl.push_back(v(0,0,0,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b00, 0,0, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b00, 0,0, 0));
    tbl.push_back(v(1,1,32'h10,1,0,0, 2'b11, 1,1,0,1, 2'b11,2'b00, 0,0, 1));
    tbl.push_back(v(1,1,32'h11,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b11, 32'h10,32'h10, 2));
    tbl.push_back(v(1,1,32'h12,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b11, 32'h11,32'h11, 2));
    tbl.push_back(v(1,1,32'h13,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b11, 32'h12,32'h12, 2));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,1,1, 2'b11,2'b11, 32'h13,32'h13, 2));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,0,1, 2'b11,2'b00, 0,0, 2));
    tbl.push_back(v(1,0,0,1,0,1, 2'b11, 1,1,0,1, 2'b11,2'b00, 0,0, 3));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,0,1, 2'b11,2'b00, 0,0, 0));
    // Stall with skid entry: 0xA, 0xB accepted, 0xC held until the drain.
    tbl.push_back(v(1,1,32'hA,0,0,0, 2'b10, 1,1,0,0, 2'b11,2'b00, 0,0, 0));
    tbl.push_back(v(1,1,32'hB,0,0,0, 2'b10, 1,1,1,0, 2'b11,2'b10, 0,32'hA, 0));
    tbl.push_back(v(1,1,32'hC,0,0,0, 2'b10, 1,1,1,0, 2'b00,2'b10, 0,32'hA, 0));
    tbl.push_back(v(1,1,32'hC,0,0,0, 2'b10, 1,1,1,0, 2'b00,2'b10, 0,32'hA, 0));
    tbl.push_back(v(1,1,32'hC,1,0,0, 2'b10, 1,1,1,0, 2'b00,2'b10, 0,32'hA, 0));
    tbl.push_back(v(1,1,32'hC,1,0,0, 2'b10, 1,1,1,0, 2'b10,2'b10, 0,32'hB, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b10, 1,1,1,0, 2'b10,2'b10, 0,32'hC, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b10, 1,1,0,0, 2'b10,2'b00, 0,0, 0));
    // Stall without skid: ready drops in the same cycle as out_ready.
    tbl.push_back(v(1,1,32'hA,0,0,0, 2'b01, 1,1,0,0, 2'b01,2'b00, 0,0, 0));
    tbl.push_back(v(1,1,32'hB,0,0,0, 2'b01, 1,1,1,0, 2'b00,2'b01, 32'hA,0, 0));
    tbl.push_back(v(1,1,32'hB,0,0,0, 2'b01, 1,1,1,0, 2'b00,2'b01, 32'hA,0, 0));
    tbl.push_back(v(1,1,32'hB,1,0,0, 2'b01, 1,1,1,0, 2'b01,2'b01, 32'hA,0, 0));
    tbl.push_back(v(1,1,32'hC,1,0,0, 2'b01, 1,1,1,0, 2'b01,2'b01, 32'hB,0, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b01, 1,1,1,0, 2'b01,2'b01, 32'hC,0, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b01, 1,1,0,0, 2'b01,2'b00, 0,0, 0));
    // Flush with SKID=1 full and SKID=0 accepting 0xD in the flush cycle.
    tbl.push_back(v(1,1,32'h1,0,0,0, 2'b11, 1,1,0,0, 2'b11,2'b00, 0,0, 0));
    tbl.push_back(v(1,1,32'h2,0,0,0, 2'b11, 1,1,1,0, 2'b10,2'b11, 32'h1,32'h1, 0));
    tbl.push_back(v(1,1,32'hD,1,1,0, 2'b11, 1,1,1,0, 2'b01,2'b11, 32'h1,32'h1, 0));
    tbl.push_back(v(1,1,32'hE,1,0,0, 2'b11, 1,1,0,0, 2'b11,2'b00, 0,0, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,1,0, 2'b11,2'b11, 32'hE,32'hE, 0));
    tbl.push_back(v(1,0,0,1,0,0, 2'b11, 1,1,0,0, 2'b11,2'b00, 0,0, 0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;  in_valid = tbl[i].iv;  in_data = tbl[i].id;
      out_ready = tbl[i].ordy;  flush = tbl[i].fl;  cnt_clr = tbl[i].clr;
      tick_check();
      for (int d = 0; d < 2; d++) begin
        if (tbl[i].msk[d]) begin
          if (tbl[i].c_ir) chk($sformatf("row%0d_ir%0d", i, d), {31'h0, ir_w[d]}, {31'h0, tbl[i].e_ir[d]});
          if (tbl[i].c_ov) chk($sformatf("row%0d_ov%0d", i, d), {31'h0, ov_w[d]}, {31'h0, tbl[i].e_ov[d]});
          if (tbl[i].c_od) chk($sformatf("row%0d_od%0d", i, d), od_w[d], (d != 0) ? tbl[i].e_od1 : tbl[i].e_od0);
          if (tbl[i].c_cnt) chk($sformatf("row%0d_cnt%0d", i, d), {16'h0, dut_cnt(d)}, {16'h0, tbl[i].e_cnt});
        end
      end
      tick_advance();
    end
    flush = 1'b0;

    // Counter saturation (CNT_W=4 saturates at 15, CNT_W=16 keeps counting) and clear.
    in_valid = 1'b0;  out_ready = 1'b1;  cnt_clr = 1'b1;
    tick_check();
    tick_advance();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_check();
      chk("sat_cnt1", {16'h0, dut_cnt(1)}, (i > 15) ? 32'd15 : i);
      chk("run_cnt0", {16'h0, cnt0}, i);
      tick_advance();
    end
    tick_check();
    chk("sat_cnt1_end", {28'h0, cnt1}, 32'd15);
    chk("run_cnt0_end", {16'h0, cnt0}, 32'd20);
    cnt_clr = 1'b1;
    tick_advance();
    cnt_clr = 1'b0;
    tick_check();
    chk("clr_cnt1", {28'h0, cnt1}, 32'd0);
    chk("clr_cnt0", {16'h0, cnt0}, 32'd0);
    tick_advance();

    // Reset while entries are held.
    in_valid = 1'b1;  out_ready = 1'b0;  in_data = 32'h55;
    tick_check();
    tick_advance();
    in_data = 32'h66;
    tick_check();
    tick_advance();
    in_valid = 1'b0;  rst_n = 1'b0;
    tick_check();
    tick_advance();
    rst_n = 1'b1;  out_ready = 1'b1;
    tick_check();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ov%0d", d), {31'h0, ov_w[d]}, 32'd0);
      chk($sformatf("rst_od%0d", d), od_w[d], 32'd0);
      chk($sformatf("rst_ir%0d", d), {31'h0, ir_w[d]}, 32'd1);
      chk($sformatf("rst_cnt%0d", d), {16'h0, dut_cnt(d)}, 32'd0);
    end
    tick_advance();

    // Random valid/ready/flush traffic.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      in_data   = $urandom;
      tick_check();
      sv = ir_w[1];
      out_ready = ~out_ready;
      #1;
      chk("ir1_comb", {31'h0, ir_w[1]}, {31'h0, sv});
      out_ready = ~out_ready;
      #1;
      tick_advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
